// File: rtl/c17_bist_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : c17_bist_ctrl
// Brief    : LFSR pattern generator + MISR response compactor driving a c17
//            block under test, with pass/fail against a golden signature.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module c17_bist_ctrl #(
  parameter int unsigned PATTERN_COUNT = 31,
  parameter int unsigned RESP_LAT      = 0,
  parameter logic [4:0]  LFSR_SEED     = 5'h01,
  parameter logic [7:0]  GOLDEN_SIG    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [4:0] pat_out,
  output logic       pat_valid,
  input  logic [1:0] resp_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature,
  output logic [4:0] pat_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] lfsr_q, lfsr_d;
  logic [7:0] sig_q, sig_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] drain_q, drain_d;
  logic       pass_q, pass_d;
  logic       pipe_clr;
  logic       cap_vld;

  assign pat_valid = (state_q == ST_RUN);
  assign pat_out   = pat_valid ? lfsr_q : 5'h00;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q & done;
  assign signature = sig_q;
  assign pat_cnt   = cnt_q;

  // An aborting cycle, or a fresh start, empties the capture pipe and captures nothing.
  assign pipe_clr = abort | (start & ((state_q == ST_IDLE) || (state_q == ST_DONE)));

  generate
    if (RESP_LAT > 0) begin : g_pipe
      logic [RESP_LAT-1:0] vpipe_q, vpipe_d;

      always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = pat_valid;
        for (int i = 1; i < RESP_LAT; i++) begin
          vpipe_d[i] = vpipe_q[i-1];
        end
        if (pipe_clr) begin
          vpipe_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vpipe_q <= '0;
        end else begin
          vpipe_q <= vpipe_d;
        end
      end

      assign cap_vld = vpipe_q[RESP_LAT-1] & ~pipe_clr;
    end else begin : g_nopipe
      assign cap_vld = pat_valid & ~pipe_clr;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    pass_d  = pass_q;

    if (abort) begin
      state_d = ST_IDLE;
      pass_d  = 1'b0;
    end else begin
      if (cap_vld) begin
        sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ {6'b0, resp_in};
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            lfsr_d  = LFSR_SEED;
            sig_d   = 8'h00;
            cnt_d   = 5'd0;
            pass_d  = 1'b0;
          end
        end
        ST_RUN: begin
          lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
          cnt_d  = cnt_q + 5'd1;
          if (cnt_d == 5'(PATTERN_COUNT)) begin
            drain_d = 2'd0;
            state_d = (RESP_LAT > 0) ? ST_DRAIN : ST_DONE;
          end
        end
        ST_DRAIN: begin
          drain_d = drain_q + 2'd1;
          if (drain_q == 2'(RESP_LAT - 1)) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Last capture lands on the same edge as DONE entry, so compare the next signature.
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
        pass_d = (sig_d == GOLDEN_SIG);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      sig_q   <= 8'h00;
      cnt_q   <= 5'd0;
      drain_q <= 2'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      pass_q  <= pass_d;
    end
  end

endmodule
`default_nettype wire
